fetch_stage: RTL

Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register. It owns the PC and drives a variable-latency instruction-memory request/ready handshake. It presents one fetched instruction per cycle, with its PC+4, to IFID. It honours a freeze (stall) from hazard detection and a taken-branch redirect from EXE, using a one-entry skid buffer and a redirect-drain state.

---
 rtl/fetch_stage_if.sv | 27 ++
 rtl/fetch_stage.sv | 135 +++++++++++++
 2 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: hazard/redirect controls, instruction-memory
// request/ready handshake, and the IFID-facing instruction outputs.
// master = the fetch stage, slave = its environment (memory + pipeline).
interface fetch_stage_if #(
  parameter int LEN = 32
);
  logic           freeze;
  logic           branch_taken;
  logic [LEN-1:0] branch_addr;
  logic           imem_req;
  logic [LEN-1:0] imem_addr;
  logic           imem_ready;
  logic [31:0]    imem_rdata;
  logic [31:0]    instruction;
  logic [LEN-1:0] pc_value;
  logic           valid;

  modport master (
    input  freeze, branch_taken, branch_addr, imem_ready, imem_rdata,
    output imem_req, imem_addr, instruction, pc_value, valid
  );

  modport slave (
    output freeze, branch_taken, branch_addr, imem_ready, imem_rdata,
    input  imem_req, imem_addr, instruction, pc_value, valid
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a variable-latency imem
// request/ready handshake and hands one instruction (with its PC+4) per
// cycle to IFID. A one-entry skid buffer absorbs a response that lands
// while frozen; a drain state retires an in-flight request after a redirect.
// Optional macro FETCH_PERF_CNT_EN adds saturating fetch/bubble counters.
module fetch_stage #(
  parameter int             LEN      = 32,
  parameter logic [LEN-1:0] RESET_PC = '0
) (
  input  logic        clock,
  input  logic        reset,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count,
`endif
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {FETCH, DRAIN, HOLD} state_t;

  state_t         state;
  logic [LEN-1:0] pc;
  logic [LEN-1:0] pc_inc;
  logic [LEN-1:0] redirect;
  logic [LEN-1:0] tgt;
  logic [LEN-1:0] skid_pc;
  logic [31:0]    skid_instr;
  logic           resp;
  logic           vld_set;
  logic           vld_clr;

  // A response only counts while a request is actually outstanding.
  assign resp          = bus.imem_req & bus.imem_ready;
  assign pc_inc        = pc + LEN'(4);
  assign redirect      = bus.branch_addr & ~LEN'(3);
  assign bus.imem_addr = pc;

  // valid is loaded with 1 on a delivered word, with 0 on a redirect or a bubble.
  assign vld_set = !bus.branch_taken && !bus.freeze &&
                   ((state == FETCH && resp) || state == HOLD);
  assign vld_clr = bus.branch_taken ||
                   (!bus.freeze && ((state == FETCH && !resp) || state == DRAIN));

  // Control FSM with registered request and IFID-facing outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= FETCH;
      pc              <= RESET_PC;
      bus.imem_req    <= 1'b0;
      bus.instruction <= '0;
      bus.pc_value    <= '0;
      bus.valid       <= 1'b0;
    end else begin
      if (vld_set) bus.valid <= 1'b1;
      else if (vld_clr) bus.valid <= 1'b0;
      case (state)
        FETCH: begin
          bus.imem_req <= 1'b1;
          if (bus.branch_taken) begin
            // With nothing in flight the redirect can take effect at once.
            if (resp || !bus.imem_req) pc <= redirect;
            else state <= DRAIN;
          end else if (resp) begin
            pc <= pc_inc;
            if (bus.freeze) begin
              state        <= HOLD;
              bus.imem_req <= 1'b0;
            end else begin
              bus.instruction <= bus.imem_rdata;
              bus.pc_value    <= pc_inc;
            end
          end
        end
        DRAIN: begin
          bus.imem_req <= 1'b1;
          if (resp) begin
            pc    <= bus.branch_taken ? redirect : tgt;
            state <= FETCH;
          end
        end
        HOLD: begin
          if (bus.branch_taken) begin
            pc           <= redirect;
            state        <= FETCH;
            bus.imem_req <= 1'b1;
          end else if (!bus.freeze) begin
            bus.instruction <= skid_instr;
            bus.pc_value    <= skid_pc;
            state           <= FETCH;
            bus.imem_req    <= 1'b1;
          end else begin
            bus.imem_req <= 1'b0;
          end
        end
        default: begin
          state        <= FETCH;
          bus.imem_req <= 1'b1;
        end
      endcase
    end
  end

  // Skid buffer captures a response that arrives while IFID is frozen.
  always_ff @(posedge clock) begin
    if (state == FETCH && resp && !bus.branch_taken && bus.freeze) begin
      skid_instr <= bus.imem_rdata;
      skid_pc    <= pc_inc;
    end
  end

  // Pending redirect target while the old request drains; latest branch wins.
  always_ff @(posedge clock) begin
    if (bus.branch_taken && !resp &&
        (state == DRAIN || (state == FETCH && bus.imem_req)))
      tgt <= redirect;
  end

`ifdef FETCH_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Saturating counts of delivered instructions and unfrozen bubbles.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_count  <= '0;
      bubble_count <= '0;
    end else begin
      if (vld_set) fetch_count <= sat_inc(fetch_count);
      if (vld_clr && !bus.freeze) bubble_count <= sat_inc(bubble_count);
    end
  end
`endif

endmodule
